// File: rtl/freq_div_pkg.sv
// Shared definitions for the programmable clock divider.
// Holds the default divisor width, the smallest legal divisor, the
// channel state type and the divisor clamp helper.
package freq_div_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int MIN_DIV   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  // Maps a captured divisor onto a legal value: 0 stays 0 (stop request),
  // 1 becomes MIN_DIV, anything else passes unchanged.
  function automatic logic [31:0] clamp_div(input logic [31:0] val);
    logic [31:0] res;
    if (val == 32'd1) begin
      res = 32'(MIN_DIV);
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/freq_div_chan.sv
// One channel of the programmable clock divider.
// Produces a 50% duty divided clock for even and odd divisors, a one-cycle
// tick at the start of every output period and a pending-divisor flag.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   en         - run enable
//   div_val    - divisor value, captured when div_load is high
//   div_load   - one-cycle capture strobe
//   clk_out    - divided clock
//   tick       - first-cycle-of-period pulse
//   div_pend   - a captured divisor is waiting to be applied
module freq_div_chan
  import freq_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = MIN_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_pend
);

  localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);

  chan_state_e      state_r;
  chan_state_e      state_s;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_s;
  logic [DIV_W-1:0] cnt_inc_s;
  logic [DIV_W-1:0] d_r;
  logic [DIV_W-1:0] d_s;
  logic [DIV_W-1:0] d_eff_s;
  logic [DIV_W-1:0] half_s;
  logic [DIV_W-1:0] pend_r;
  logic             pend_vld_r;
  logic             p_r;
  logic             p_s;
  logic             n_r;
  logic             tick_r;
  logic             tick_s;
  logic             apply_s;
  logic             wrap_s;

  // Derived values: divisor that would be in force if the pending one were
  // applied now, half period (rounded up for odd divisors) and wrap detect.
  always_comb begin
    if (pend_vld_r) begin
      d_eff_s = pend_r;
    end else begin
      d_eff_s = d_r;
    end
    half_s    = (d_r >> 1) + {{(DIV_W-1){1'b0}}, d_r[0]};
    cnt_inc_s = cnt_r + ONE_D;
    wrap_s    = (cnt_r == (d_r - ONE_D));
  end

  // Next-state logic for the channel FSM, counter, phase and divisor.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    p_s     = p_r;
    d_s     = d_r;
    tick_s  = 1'b0;
    apply_s = 1'b0;
    case (state_r)
      IDLE: begin
        // A pending divisor is taken on every idle edge, enabled or not.
        apply_s = pend_vld_r;
        d_s     = d_eff_s;
        cnt_s   = '0;
        if (en && (d_eff_s != '0)) begin
          state_s = RUN;
          p_s     = 1'b1;
          tick_s  = 1'b1;
        end else begin
          state_s = IDLE;
          p_s     = 1'b0;
        end
      end
      RUN: begin
        if (!en) begin
          state_s = IDLE;
          cnt_s   = '0;
          p_s     = 1'b0;
          apply_s = pend_vld_r;
          d_s     = d_eff_s;
        end else if (wrap_s) begin
          // Period boundary: the new divisor only ever takes effect here.
          cnt_s   = '0;
          apply_s = pend_vld_r;
          d_s     = d_eff_s;
          if (d_eff_s == '0) begin
            state_s = IDLE;
            p_s     = 1'b0;
          end else begin
            state_s = RUN;
            p_s     = 1'b1;
            tick_s  = 1'b1;
          end
        end else begin
          cnt_s = cnt_inc_s;
          p_s   = (cnt_inc_s < half_s);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        p_s     = 1'b0;
        d_s     = DEF_D;
      end
    endcase
  end

  // Posedge state registers: FSM, counter, phase, active divisor, tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      p_r     <= 1'b0;
      d_r     <= DEF_D;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      p_r     <= p_s;
      d_r     <= d_s;
      tick_r  <= tick_s;
    end
  end

  // Pending divisor capture; a load on the apply edge keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r     <= '0;
      pend_vld_r <= 1'b0;
    end else if (div_load) begin
      pend_r     <= DIV_W'(clamp_div(32'(div_val)));
      pend_vld_r <= 1'b1;
    end else if (apply_s) begin
      pend_vld_r <= 1'b0;
    end else begin
      pend_vld_r <= pend_vld_r;
    end
  end

  // Half-cycle delayed copy of the phase, used to trim odd high times.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      n_r <= 1'b0;
    end else begin
      n_r <= p_r;
    end
  end

  // Odd divisors AND the two phase flops so the high time is D/2 cycles.
  // Only one of the two flops changes at any instant, so the AND cannot
  // glitch; the output depends on flops only.
  assign clk_out  = d_r[0] ? (p_r & n_r) : p_r;
  assign tick     = tick_r;
  assign div_pend = pend_vld_r;

endmodule

// File: rtl/freq_div_prog.sv
// Multi-channel runtime-programmable clock divider.
// Each channel is an independent freq_div_chan with its own divisor.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   en         - per-channel run enable
//   div_val    - packed divisors, channel i at [i*DIV_W +: DIV_W]
//   div_load   - per-channel divisor capture strobe
//   clk_out    - per-channel divided clock
//   tick       - per-channel period-start pulse
//   div_pend   - per-channel pending-divisor flag
module freq_div_prog
  import freq_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int DEF_DIV  = MIN_DIV
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*DIV_W-1:0] div_val,
  input  logic [CHANNELS-1:0]       div_load,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       div_pend
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    freq_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .div_val  (div_val[i*DIV_W +: DIV_W]),
      .div_load (div_load[i]),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .div_pend (div_pend[i])
    );
  end

endmodule
